// File: rtl/count_event_capture_pkg.sv
// count_event_capture_pkg: event type codes, record layout offsets and drop counter width
package count_event_capture_pkg;
   localparam logic [1:0] EV_NONE = 2'b00;
   localparam logic [1:0] EV_STEP = 2'b01;
   localparam logic [1:0] EV_WRAP = 2'b10;
   localparam logic [1:0] EV_JUMP = 2'b11;
   localparam int TYPE_W = 2;
   localparam int DROP_W = 8;
   // record layout is {type, count, ts}; ts occupies the low bits
   function automatic int ts_lsb();
      return 0;
   endfunction
   function automatic int cnt_lsb(input int ts_w);
      return ts_w;
   endfunction
   function automatic int type_lsb(input int cnt_w, input int ts_w);
      return cnt_w + ts_w;
   endfunction
endpackage

// File: rtl/count_event_capture_sync_fifo.sv
// sync_fifo: power-of-2 depth FIFO with registered head, level count and push-through-when-popping on full
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;
   assign full_o  = level_q == (AW+1)'(DEPTH);
   assign empty_o = level_q == '0;
   assign level_o = level_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   // pointers wrap naturally because DEPTH is a power of 2
   always_comb begin
      wr_d    = do_push ? wr_q + AW'(1) : wr_q;
      rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
      level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end
endmodule

// File: rtl/count_event_capture.sv
// count_event_capture: classifies counter changes as STEP/WRAP/JUMP and queues timestamped records
module count_event_capture
   import count_event_capture_pkg::*;
#(
   parameter int CNT_W = 4,
   parameter int TS_W  = 12,
   parameter int DEPTH = 8,
   localparam int REC_W = TYPE_W + CNT_W + TS_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CNT_W-1:0]         count_in,
   input  logic                     capture_en,
   input  logic [2:0]               event_mask,
   input  logic                     ovf_clear,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [REC_W-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_cnt
);
   logic [TS_W-1:0]   ts_q, ts_d;
   logic [CNT_W-1:0]  prev_q;
   logic              prev_valid_q;
   logic              overflow_q, overflow_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic [1:0]        ev_type;
   logic [REC_W-1:0]  rec;
   logic              push_req, pop, full, empty, drop;
   always_comb begin
      ev_type = EV_NONE;
      if (prev_valid_q && count_in != prev_q)
         ev_type = (prev_q == '1 && count_in == '0) ? EV_WRAP :
                   (count_in == prev_q + CNT_W'(1)) ? EV_STEP : EV_JUMP;
   end
   assign rec      = {ev_type, count_in, ts_q};
   assign push_req = ev_type != EV_NONE && capture_en && event_mask[ev_type - 2'd1];
   assign pop      = out_valid && out_ready;
   assign drop     = push_req && full && !pop;
   assign out_valid = !empty;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_q;
   // a drop in the same cycle as a clear restarts the count at one
   always_comb begin
      ts_d       = ts_q + TS_W'(1);
      overflow_d = drop ? 1'b1 : ovf_clear ? 1'b0 : overflow_q;
      drop_d     = drop ? (ovf_clear ? DROP_W'(1) : drop_q == '1 ? drop_q : drop_q + DROP_W'(1)) :
                   ovf_clear ? '0 : drop_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts_q         <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         drop_q       <= '0;
      end else begin
         ts_q         <= ts_d;
         prev_q       <= count_in;
         prev_valid_q <= 1'b1;
         overflow_q   <= overflow_d;
         drop_q       <= drop_d;
      end
   end
   sync_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (push_req),
      .wdata_i (rec),
      .pop_i   (pop),
      .rdata_o (out_data),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );
endmodule
